// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: combination-lock sequencing for the board lock design.
//   Takes digit pulses from the debounced entry path and compares them against
//   a stored N-digit code. The first digit entered is the most significant one.
//   Consecutive wrong codes lead to a timed lockout. A partial entry is dropped
//   after an idle timeout. The code can be reprogrammed while unlocked.
//
// Ports:
//   clk          in   system clock, rising edge
//   btnU         in   synchronous active-high reset
//   entry_valid  in   single-cycle pulse, entry_digit valid
//   entry_digit  in   [DIGIT_W-1:0] digit value
//   relock       in   single-cycle pulse, return to locked
//   prog_req     in   single-cycle pulse, start reprogramming (UNLOCKED only)
//   unlocked     out  1 in UNLOCKED
//   lockout      out  1 in LOCKOUT
//   programming  out  1 in PROGRAM
//   state_code   out  [2:0] current state encoding
//   digit_cnt    out  digits taken in the current ENTER/PROGRAM sequence
//   fail_cnt     out  consecutive failed attempts
//   last_digit   out  most recently accepted digit
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | locked, waiting for the first digit
// ENTER    | collecting digits, mismatch tracked in a sticky flag
// UNLOCKED | correct code entered, waiting for relock or prog_req
// PROGRAM  | collecting new code digits into the shadow register
// LOCKOUT  | too many failures, all inputs ignored until the timer expires
module combo_lock_ctrl #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic                                  clk,
    input  logic                                  btnU,
    input  logic                                  entry_valid,
    input  logic [DIGIT_W-1:0]                    entry_digit,
    input  logic                                  relock,
    input  logic                                  prog_req,
    output logic                                  unlocked,
    output logic                                  lockout,
    output logic                                  programming,
    output logic [2:0]                            state_code,
    output logic [$clog2(NUM_DIGITS+1)-1:0]       digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]         fail_cnt,
    output logic [DIGIT_W-1:0]                    last_digit
);

    localparam int unsigned CODE_W  = NUM_DIGITS * DIGIT_W;
    localparam int unsigned DCNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned FCNT_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [TMR_W-1:0]  TMR_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(NUM_DIGITS - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX    = FCNT_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTER    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PROGRAM  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic [DCNT_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [DIGIT_W-1:0]  last_digit_q, last_digit_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                mism_q, mism_d;
    logic                unlocked_q, lockout_q, programming_q;

    logic [DIGIT_W-1:0]  exp_digit;
    logic [CODE_W-1:0]   shifted;
    logic                is_last;
    logic                tmr_zero;
    logic                mism_now;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        shadow_d     = shadow_q;
        digit_cnt_d  = digit_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        last_digit_d = last_digit_q;
        tmr_d        = tmr_q;
        mism_d       = mism_q;
        mism_now     = 1'b0;

        exp_digit = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (digit_cnt_q == DCNT_W'(i))
                exp_digit = code_q[CODE_W-1-i*DIGIT_W -: DIGIT_W];
        end
        shifted  = (shadow_q << DIGIT_W) | CODE_W'(entry_digit);
        is_last  = (digit_cnt_q == DCNT_LAST);
        tmr_zero = (tmr_q == '0);

        case (state_q)
            // IDLE shares the digit path with ENTER so that a one-digit code
            // completes on the very first accepted digit.
            ST_IDLE, ST_ENTER: begin
                if (entry_valid) begin
                    last_digit_d = entry_digit;
                    mism_now = ((state_q == ST_ENTER) && mism_q) || (entry_digit != exp_digit);
                    if (is_last) begin
                        digit_cnt_d = '0;
                        mism_d      = 1'b0;
                        if (!mism_now) begin
                            state_d    = ST_UNLOCKED;
                            fail_cnt_d = '0;
                        end else if (fail_cnt_q >= FCNT_MAX - FCNT_W'(1)) begin
                            state_d    = ST_LOCKOUT;
                            fail_cnt_d = FCNT_MAX;
                            tmr_d      = TMR_LOCKOUT;
                        end else begin
                            state_d    = ST_IDLE;
                            fail_cnt_d = fail_cnt_q + FCNT_W'(1);
                        end
                    end else begin
                        state_d     = ST_ENTER;
                        digit_cnt_d = digit_cnt_q + DCNT_W'(1);
                        mism_d      = mism_now;
                        tmr_d       = TMR_TIMEOUT;
                    end
                end else if (state_q == ST_ENTER) begin
                    if (tmr_zero) begin
                        state_d     = ST_IDLE;
                        digit_cnt_d = '0;
                        mism_d      = 1'b0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
            end
            ST_UNLOCKED: begin
                if (relock) begin
                    state_d = ST_IDLE;
                end else if (prog_req) begin
                    state_d     = ST_PROGRAM;
                    digit_cnt_d = '0;
                    tmr_d       = TMR_TIMEOUT;
                end
            end
            ST_PROGRAM: begin
                if (relock) begin
                    state_d     = ST_IDLE;
                    digit_cnt_d = '0;
                end else if (entry_valid) begin
                    last_digit_d = entry_digit;
                    if (is_last) begin
                        code_d      = shifted;
                        state_d     = ST_IDLE;
                        digit_cnt_d = '0;
                    end else begin
                        shadow_d    = shifted;
                        digit_cnt_d = digit_cnt_q + DCNT_W'(1);
                        tmr_d       = TMR_TIMEOUT;
                    end
                end else if (tmr_zero) begin
                    state_d     = ST_UNLOCKED;
                    digit_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                digit_cnt_d = '0;
                mism_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (btnU) begin
            state_q       <= ST_IDLE;
            code_q        <= DEFAULT_CODE;
            shadow_q      <= '0;
            digit_cnt_q   <= '0;
            fail_cnt_q    <= '0;
            last_digit_q  <= '0;
            tmr_q         <= '0;
            mism_q        <= 1'b0;
            unlocked_q    <= 1'b0;
            lockout_q     <= 1'b0;
            programming_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            digit_cnt_q   <= digit_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            last_digit_q  <= last_digit_d;
            tmr_q         <= tmr_d;
            mism_q        <= mism_d;
            unlocked_q    <= (state_d == ST_UNLOCKED);
            lockout_q     <= (state_d == ST_LOCKOUT);
            programming_q <= (state_d == ST_PROGRAM);
        end
    end

    assign unlocked    = unlocked_q;
    assign lockout     = lockout_q;
    assign programming = programming_q;
    assign state_code  = state_q;
    assign digit_cnt   = digit_cnt_q;
    assign fail_cnt    = fail_cnt_q;
    assign last_digit  = last_digit_q;

endmodule
